seg7_score_scan: RTL

Downstream consumer of the score binary-to-BCD converter: takes its three BCD digits (hundreds, tens, ones) and drives a common-anode, time-multiplexed seven-segment display. It snapshots new scores on a load strobe, commits them only at scan-frame boundaries so a frame never mixes digits from two scores, blanks leading zeros, and inserts a dead-time between digit slots to suppress ghosting.

---
 rtl/seg7_score_scan_if.sv | 22 ++
 rtl/seg7_score_scan.sv | 118 +++++++++++
 2 files changed

// File: rtl/seg7_score_scan_if.sv
// rtl/seg7_score_scan_if.sv - score input and display output bundle for seg7_score_scan
interface seg7_score_scan_if;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       load;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  // Score source / display observer side
  modport master (
    output hundreds, tens, ones, load,
    input  an, seg, dp
  );

  // Display driver side
  modport slave (
    input  hundreds, tens, ones, load,
    output an, seg, dp
  );
endinterface

// File: rtl/seg7_score_scan.sv
// rtl/seg7_score_scan.sv - frame-coherent multiplexed 3-digit seven-segment score display
module seg7_score_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 2000
) (
  input logic              clk,
  input logic              rst_n,
  seg7_score_scan_if.slave bus
);

  localparam int             CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]  CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]  CNT_DEAD = CW'(DEAD_CYCLES);
  localparam logic [6:0]     SEG_OFF  = 7'b1111111;
  localparam logic [3:0]     AN_OFF   = 4'b1111;

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD codes show a dash
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [11:0]   shadow_q, shadow_d;
  logic [11:0]   disp_q, disp_d;
  logic          pending_q, pending_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic          slot_end;
  logic          commit;
  logic          dead;
  logic [3:0]    digit;
  logic          blank;

  // Slot/digit sequencing and frame-boundary commit of the shadowed score
  always_comb begin
    slot_end  = (cnt_q == CNT_LAST);
    commit    = slot_end && (idx_q == 2'd2) && pending_q;
    cnt_d     = slot_end ? '0 : cnt_q + CW'(1);
    idx_d     = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end
    // A load coinciding with a commit keeps pending set so it commits next frame
    shadow_d  = bus.load ? {bus.hundreds, bus.tens, bus.ones} : shadow_q;
    pending_d = bus.load ? 1'b1 : (commit ? 1'b0 : pending_q);
    disp_d    = commit ? shadow_q : disp_q;
  end

  // Output pattern for the current slot, with leading-zero blanking and dead-time
  always_comb begin
    dead  = (cnt_q < CNT_DEAD);
    digit = disp_q[3:0];
    blank = 1'b0;
    an_d  = AN_OFF;
    case (idx_q)
      2'd1: begin
        digit   = disp_q[7:4];
        blank   = (disp_q[11:8] == 4'd0) && (disp_q[7:4] == 4'd0);
        an_d[1] = 1'b0;
      end
      2'd2: begin
        digit   = disp_q[11:8];
        blank   = (disp_q[11:8] == 4'd0);
        an_d[2] = 1'b0;
      end
      default: begin
        an_d[0] = 1'b0;
      end
    endcase
    seg_d = blank ? SEG_OFF : seg_decode(digit);
    if (dead) begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
    end
  end

  // State and registered display outputs; reset discards any pending score
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      shadow_q  <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      an_q      <= AN_OFF;
      seg_q     <= SEG_OFF;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = 1'b1;

endmodule
